lsu_pipelined: RTL and testbench
================================

Name: lsu_pipelined

Overview:
- Registered-response load/store unit for the pipelined RV32I core; replaces the combinational-read LSU in the MEM stage.
- Decodes the memory-mapped address space into data memory, output peripherals and input peripherals.
- Returns load data one cycle after request; flags misaligned, illegal-length and unmapped accesses.
- Adds input synchronisers, sticky button-edge capture with write-1-to-clear, and a parametrised data memory depth.

Parameters:
DMEM_AW, 13, data memory byte-address width (depth = 2**DMEM_AW bytes, mapped at 0x2000 and mirrored within addr[15:13]==3'b001 region)
SW_W, 32, switch input width (zero-extended to 32 on read)
BTN_W, 4, button input width (1..8)
SYNC_STAGES, 2, flip-flop stages on i_io_sw / i_io_btn (>=2)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_req  in  1  access request this cycle
i_wren  in  1  1=store, 0=load (qualified by i_req)
i_func3  in  3  RV32I funct3: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW
i_addr  in  32  byte address
i_st_data  in  32  store data, LSB-aligned
i_io_sw  in  SW_W  raw switches
i_io_btn  in  BTN_W  raw buttons, active-high
o_rsp_valid  out  1  response for request of previous cycle
o_err  out  1  access error, valid with o_rsp_valid
o_ld_data  out  32  extended load data, valid with o_rsp_valid on a load
o_io_ledr  out  32  red LEDs
o_io_ledg  out  32  green LEDs
o_io_hex0..o_io_hex7  out  7 each  seven-segment digits
o_io_lcd  out  32  LCD control word

Behaviour:
- Reset value, outputs: o_rsp_valid, o_err, o_ld_data, all o_io_* = 0.
- Reset value, internal state: synchroniser chains, edge register and output registers = 0.
- Data memory contents are not reset.
- Address decode:
  - DMEM: addr[15:13]==001.
  - OUT: addr[15:6]==10'h1C0 (0x7000-0x703F).
  - IN: addr[15:5]==11'h3C0 (0x7800-0x781F).
  - Anything else is unmapped. addr[31:16] is ignored.
- OUT map: LEDR 0x7000-03, LEDG 0x7010-13, HEX0..7 bytes 0x7020-27 (output bit[6:0], stored bit7 reads back), LCD 0x7030-33. Other OUT bytes read 0; writes to them are dropped, no error.
- IN map:
  - SW 0x7800, synchronised, zero-extended.
  - BTN 0x7810, synchronised level, zero-extended.
  - BTN_EDGE 0x7814, sticky rising-edge flags.
  - Other IN bytes read 0.
  - Stores to IN affect only BTN_EDGE: write-1-to-clear on bits [BTN_W-1:0]. Other IN stores are dropped, no error.
- Edge capture: a bit sets when the last sync stage is 1 and the previous sample was 0. Set has priority over a simultaneous W1C of the same bit.
- Error conditions (any one sets o_err):
  - Unmapped address.
  - Load func3 in {011,110,111}.
  - Store func3[2]==1 or func3==011.
  - Halfword access with addr[0]!=0.
  - Word access with addr[1:0]!=0.
- Error handling: an errored store writes nothing. An errored load returns o_ld_data=0.
- Timing: a request accepted at edge N gives o_rsp_valid=1 for exactly the cycle after edge N, with o_err and o_ld_data registered at edge N. No request means o_rsp_valid=0 and o_ld_data holds its previous value.
- Throughput: one request per cycle, back-to-back, no stall; there is no ready signal.
- Stores: write bytes at edge N. An SB/SH/SW touches exactly 1/2/4 bytes; other bytes are unchanged.
- Read-after-write: a load in cycle N+1 to a location stored in cycle N returns the new data. A load in the same cycle as a store is impossible (single port).
- Load extension uses func3 registered with the request: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Byte/halfword loads select the addressed lanes, so LBU at 0x7022 returns HEX2.
- Peripheral outputs change the cycle after the store edge (direct register outputs).
- Asynchronous reset mid-transaction: the pending response is discarded, o_rsp_valid drops immediately, and output peripherals clear to 0.

Test Plan:
- SW 0x12345678 to 0x2004, then LW/LH/LHU/LB/LBU at 0x2004/0x2006/0x2007 -> 0x12345678, 0x00001234, 0x00001234, 0x00000012, 0x00000012; each response exactly one cycle after its request.
- SB 0x80 to 0x2001, then LB 0x2001 -> 0xFFFFFF80; LBU -> 0x00000080; bytes 0x2000/0x2002 unchanged.
- Back-to-back SW 0xDEADBEEF to 0x7000, LW 0x7000 next cycle -> o_io_ledr=0xDEADBEEF one cycle after the store; load returns 0xDEADBEEF. SB 0x3F to 0x7025 -> o_io_hex5=7'h3F, other HEX unchanged.
- LW 0x2002, SH 0x2003, LW 0x9000, load func3=011 -> o_err=1 each time, o_ld_data=0, memory unchanged.
- Pulse i_io_btn[1] high for 5 cycles -> BTN_EDGE reads 0x2 after SYNC_STAGES+1 cycles and stays 0x2 after release. SB 0x02 to 0x7814 -> reads 0. Issue W1C in the same cycle as a new rising edge -> bit stays set.
- Assert i_rst_n low while o_rsp_valid=1 with LEDR=0xFF -> o_rsp_valid=0 and o_io_ledr=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/lsu_pipelined.sv
// Load/store unit for the pipelined RV32I MEM stage: decodes DMEM / output / input
// peripherals and returns a registered response one cycle after each request.
`timescale 1ns/1ps
module lsu_pipelined #(
    parameter int unsigned DMEM_AW     = 13,
    parameter int unsigned SW_W        = 32,
    parameter int unsigned BTN_W       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic              i_wren,
    input  logic [2:0]        i_func3,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_st_data,
    input  logic [SW_W-1:0]   i_io_sw,
    input  logic [BTN_W-1:0]  i_io_btn,
    output logic              o_rsp_valid,
    output logic              o_err,
    output logic [31:0]       o_ld_data,
    output logic [31:0]       o_io_ledr,
    output logic [31:0]       o_io_ledg,
    output logic [6:0]        o_io_hex0,
    output logic [6:0]        o_io_hex1,
    output logic [6:0]        o_io_hex2,
    output logic [6:0]        o_io_hex3,
    output logic [6:0]        o_io_hex4,
    output logic [6:0]        o_io_hex5,
    output logic [6:0]        o_io_hex6,
    output logic [6:0]        o_io_hex7,
    output logic [31:0]       o_io_lcd
);

    localparam int unsigned WIDX_W     = DMEM_AW - 2;
    localparam int unsigned DMEM_WORDS = 2 ** WIDX_W;

    logic [31:0] r_dmem [DMEM_WORDS];

    logic [31:0] r_ledr, r_ledg, r_lcd, r_hex_lo, r_hex_hi;
    logic [SYNC_STAGES-1:0][SW_W-1:0]  r_sw_sync;
    logic [SYNC_STAGES-1:0][BTN_W-1:0] r_btn_sync;
    logic [BTN_W-1:0] r_btn_prev, r_edge;
    logic        r_rsp_valid, r_err;
    logic [31:0] r_ld_data;

    logic              w_is_dmem, w_is_out, w_is_in;
    logic              w_f3_bad, w_misalign, w_err;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata, w_rword, w_lane, w_ld_ext;
    logic              w_st_ok, w_st_dmem, w_st_out, w_st_in;
    logic [WIDX_W-1:0] w_widx;
    logic [BTN_W-1:0]  w_btn_s, w_rise, w_clr;
    logic              w_unused;

    assign w_unused = ^i_addr[31:16];

    function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int k = 0; k < 4; k++)
            res[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
        return res;
    endfunction

    // Address decode, error detection and store lane alignment
    always_comb begin
        w_is_dmem = (i_addr[15:13] == 3'b001);
        w_is_out  = (i_addr[15:6] == 10'h1C0);
        w_is_in   = (i_addr[15:5] == 11'h3C0);
        if (i_wren)
            w_f3_bad = i_func3[2] | (i_func3[1:0] == 2'b11);
        else
            w_f3_bad = (i_func3 == 3'b011) | (i_func3[2:1] == 2'b11);
        w_misalign = ((i_func3[1:0] == 2'b01) & i_addr[0])
                   | ((i_func3[1:0] == 2'b10) & (i_addr[1:0] != 2'b00));
        w_err = ~(w_is_dmem | w_is_out | w_is_in) | w_f3_bad | w_misalign;

        if (i_func3[1:0] == 2'b00)
            w_be = 4'b0001 << i_addr[1:0];
        else if (i_func3[1:0] == 2'b01)
            w_be = 4'b0011 << i_addr[1:0];
        else
            w_be = 4'b1111;
        w_wdata = i_st_data << {i_addr[1:0], 3'b000};

        w_st_ok   = i_req & i_wren & ~w_err;
        w_st_dmem = w_st_ok & w_is_dmem;
        w_st_out  = w_st_ok & w_is_out;
        w_st_in   = w_st_ok & w_is_in;
        w_widx    = i_addr[DMEM_AW-1:2];
    end

    // Read word mux and load lane select / extension
    always_comb begin
        w_rword = '0;
        if (w_is_dmem) begin
            w_rword = r_dmem[w_widx];
        end else if (w_is_out) begin
            case (i_addr[5:2])
                4'h0:    w_rword = r_ledr;
                4'h4:    w_rword = r_ledg;
                4'h8:    w_rword = r_hex_lo;
                4'h9:    w_rword = r_hex_hi;
                4'hC:    w_rword = r_lcd;
                default: w_rword = '0;
            endcase
        end else if (w_is_in) begin
            case (i_addr[4:2])
                3'd0:    w_rword = 32'(r_sw_sync[SYNC_STAGES-1]);
                3'd4:    w_rword = 32'(r_btn_sync[SYNC_STAGES-1]);
                3'd5:    w_rword = 32'(r_edge);
                default: w_rword = '0;
            endcase
        end

        w_lane = w_rword >> {i_addr[1:0], 3'b000};
        case (i_func3)
            3'b000:  w_ld_ext = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_ld_ext = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_ld_ext = {24'h0, w_lane[7:0]};
            3'b101:  w_ld_ext = {16'h0, w_lane[15:0]};
            default: w_ld_ext = w_lane;
        endcase
    end

    // Data memory: byte-enabled word array, intentionally not reset
    always_ff @(posedge i_clk) begin
        if (w_st_dmem) begin
            for (int k = 0; k < 4; k++)
                if (w_be[k]) r_dmem[w_widx][8*k +: 8] <= w_wdata[8*k +: 8];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ledr   <= '0;
            r_ledg   <= '0;
            r_hex_lo <= '0;
            r_hex_hi <= '0;
            r_lcd    <= '0;
        end else if (w_st_out) begin
            case (i_addr[5:2])
                4'h0:    r_ledr   <= be_merge(r_ledr, w_wdata, w_be);
                4'h4:    r_ledg   <= be_merge(r_ledg, w_wdata, w_be);
                4'h8:    r_hex_lo <= be_merge(r_hex_lo, w_wdata, w_be);
                4'h9:    r_hex_hi <= be_merge(r_hex_hi, w_wdata, w_be);
                4'hC:    r_lcd    <= be_merge(r_lcd, w_wdata, w_be);
                default: ;
            endcase
        end
    end

    // Input synchronisers and sticky rising-edge capture; set beats W1C
    always_comb begin
        w_btn_s = r_btn_sync[SYNC_STAGES-1];
        w_rise  = w_btn_s & ~r_btn_prev;
        w_clr   = '0;
        if (w_st_in && (i_addr[4:2] == 3'd5) && w_be[0])
            w_clr = w_wdata[BTN_W-1:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sw_sync  <= '0;
            r_btn_sync <= '0;
            r_btn_prev <= '0;
            r_edge     <= '0;
        end else begin
            r_sw_sync  <= {r_sw_sync[SYNC_STAGES-2:0], i_io_sw};
            r_btn_sync <= {r_btn_sync[SYNC_STAGES-2:0], i_io_btn};
            r_btn_prev <= w_btn_s;
            r_edge     <= (r_edge & ~w_clr) | w_rise;
        end
    end

    // Registered response; load data holds when no load is issued
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_valid <= 1'b0;
            r_err       <= 1'b0;
            r_ld_data   <= '0;
        end else begin
            r_rsp_valid <= i_req;
            r_err       <= i_req & w_err;
            if (i_req && !i_wren)
                r_ld_data <= w_err ? 32'h0 : w_ld_ext;
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_err       = r_err;
    assign o_ld_data   = r_ld_data;
    assign o_io_ledr   = r_ledr;
    assign o_io_ledg   = r_ledg;
    assign o_io_lcd    = r_lcd;
    assign o_io_hex0   = r_hex_lo[6:0];
    assign o_io_hex1   = r_hex_lo[14:8];
    assign o_io_hex2   = r_hex_lo[22:16];
    assign o_io_hex3   = r_hex_lo[30:24];
    assign o_io_hex4   = r_hex_hi[6:0];
    assign o_io_hex5   = r_hex_hi[14:8];
    assign o_io_hex6   = r_hex_hi[22:16];
    assign o_io_hex7   = r_hex_hi[30:24];

endmodule

// File: tb/tb_lsu_pipelined.sv
// Directed self-checking bench for lsu_pipelined with hand-computed expectations.
`timescale 1ns/1ps
module tb_lsu_pipelined;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_req, i_wren;
    logic [2:0]  i_func3;
    logic [31:0] i_addr, i_st_data;
    logic [31:0] i_io_sw;
    logic [3:0]  i_io_btn;
    logic        o_rsp_valid, o_err;
    logic [31:0] o_ld_data, o_io_ledr, o_io_ledg, o_io_lcd;
    logic [6:0]  o_io_hex0, o_io_hex1, o_io_hex2, o_io_hex3;
    logic [6:0]  o_io_hex4, o_io_hex5, o_io_hex6, o_io_hex7;

    int n_checks;
    int n_fail;

    lsu_pipelined #(.DMEM_AW(13), .SW_W(32), .BTN_W(4), .SYNC_STAGES(2)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_wren(i_wren),
        .i_func3(i_func3), .i_addr(i_addr), .i_st_data(i_st_data),
        .i_io_sw(i_io_sw), .i_io_btn(i_io_btn),
        .o_rsp_valid(o_rsp_valid), .o_err(o_err), .o_ld_data(o_ld_data),
        .o_io_ledr(o_io_ledr), .o_io_ledg(o_io_ledg),
        .o_io_hex0(o_io_hex0), .o_io_hex1(o_io_hex1), .o_io_hex2(o_io_hex2),
        .o_io_hex3(o_io_hex3), .o_io_hex4(o_io_hex4), .o_io_hex5(o_io_hex5),
        .o_io_hex6(o_io_hex6), .o_io_hex7(o_io_hex7), .o_io_lcd(o_io_lcd)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_req(input logic wren, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
        i_req     = 1'b1;
        i_wren    = wren;
        i_func3   = f3;
        i_addr    = a;
        i_st_data = d;
        tick();
        i_req  = 1'b0;
        i_wren = 1'b0;
    endtask

    task automatic ld(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] exp, input logic exp_err);
        do_req(1'b0, f3, a, 32'h0);
        check({tag, "_vld"}, 32'(o_rsp_valid), 32'd1);
        check({tag, "_err"}, 32'(o_err), 32'(exp_err));
        check(tag, o_ld_data, exp_err ? 32'h0 : exp);
    endtask

    task automatic st(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d, input logic exp_err);
        do_req(1'b1, f3, a, d);
        check({tag, "_vld"}, 32'(o_rsp_valid), 32'd1);
        check({tag, "_err"}, 32'(o_err), 32'(exp_err));
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        i_rst_n   = 1'b0;
        i_req     = 1'b0;
        i_wren    = 1'b0;
        i_func3   = 3'b000;
        i_addr    = 32'h0;
        i_st_data = 32'h0;
        i_io_sw   = 32'h0;
        i_io_btn  = 4'h0;
        tick();
        tick();
        check("rst_valid", 32'(o_rsp_valid), 32'd0);
        check("rst_err",   32'(o_err), 32'd0);
        check("rst_ld",    o_ld_data, 32'h0);
        check("rst_ledr",  o_io_ledr, 32'h0);
        check("rst_hex0",  32'(o_io_hex0), 32'h0);
        check("rst_lcd",   o_io_lcd, 32'h0);
        i_rst_n = 1'b1;
        tick();

        // Word store then every load flavour
        st("sw_2004", 3'b010, 32'h2004, 32'h12345678, 1'b0);
        ld("lw_2004",  3'b010, 32'h2004, 32'h12345678, 1'b0);
        ld("lh_2006",  3'b001, 32'h2006, 32'h00001234, 1'b0);
        ld("lhu_2006", 3'b101, 32'h2006, 32'h00001234, 1'b0);
        ld("lb_2007",  3'b000, 32'h2007, 32'h00000012, 1'b0);
        ld("lbu_2007", 3'b100, 32'h2007, 32'h00000012, 1'b0);
        ld("lh_2004",  3'b001, 32'h2004, 32'h00005678, 1'b0);
        tick();
        check("idle_vld",  32'(o_rsp_valid), 32'd0);
        check("idle_hold", o_ld_data, 32'h00005678);

        // Byte store and sign extension
        st("sw_2000", 3'b010, 32'h2000, 32'h11223344, 1'b0);
        st("sb_2001", 3'b000, 32'h2001, 32'h00000080, 1'b0);
        ld("lb_2001",  3'b000, 32'h2001, 32'hFFFFFF80, 1'b0);
        ld("lbu_2001", 3'b100, 32'h2001, 32'h00000080, 1'b0);
        ld("lbu_2000", 3'b100, 32'h2000, 32'h00000044, 1'b0);
        ld("lbu_2002", 3'b100, 32'h2002, 32'h00000022, 1'b0);
        ld("lw_2000",  3'b010, 32'h2000, 32'h11228044, 1'b0);
        ld("lh_2000",  3'b001, 32'h2000, 32'hFFFF8044, 1'b0);

        // Output peripherals, back-to-back store/load
        st("sw_ledr", 3'b010, 32'h7000, 32'hDEADBEEF, 1'b0);
        check("ledr_out", o_io_ledr, 32'hDEADBEEF);
        ld("lw_ledr", 3'b010, 32'h7000, 32'hDEADBEEF, 1'b0);
        st("sw_hexlo", 3'b010, 32'h7020, 32'h04030201, 1'b0);
        st("sw_hexhi", 3'b010, 32'h7024, 32'h08070605, 1'b0);
        st("sb_hex5",  3'b000, 32'h7025, 32'h0000003F, 1'b0);
        check("hex5", 32'(o_io_hex5), 32'h3F);
        check("hex4", 32'(o_io_hex4), 32'h05);
        check("hex6", 32'(o_io_hex6), 32'h07);
        check("hex0", 32'(o_io_hex0), 32'h01);
        check("hex7", 32'(o_io_hex7), 32'h08);
        ld("lbu_hex2", 3'b100, 32'h7022, 32'h00000003, 1'b0);
        st("sb_hex6", 3'b000, 32'h7026, 32'h000000FF, 1'b0);
        check("hex6_b7", 32'(o_io_hex6), 32'h7F);
        ld("lbu_hex6", 3'b100, 32'h7026, 32'h000000FF, 1'b0);
        ld("lb_hex6",  3'b000, 32'h7026, 32'hFFFFFFFF, 1'b0);
        ld("lw_hexhi", 3'b010, 32'h7024, 32'h08FF3F05, 1'b0);
        st("sw_lcd", 3'b010, 32'h7030, 32'hCAFE0001, 1'b0);
        check("lcd_out", o_io_lcd, 32'hCAFE0001);
        st("sw_gap",  3'b010, 32'h703C, 32'h12345678, 1'b0);
        ld("lw_gap",  3'b010, 32'h703C, 32'h0, 1'b0);

        // Errors: misaligned, bad funct3, unmapped
        ld("lw_2000b", 3'b010, 32'h2000, 32'h11228044, 1'b0);
        ld("lw_mis",   3'b010, 32'h2002, 32'h0, 1'b1);
        st("sh_mis",   3'b001, 32'h2003, 32'h0000BEEF, 1'b1);
        ld("lw_unmap", 3'b010, 32'h9000, 32'h0, 1'b1);
        ld("ld_f3011", 3'b011, 32'h2000, 32'h0, 1'b1);
        ld("ld_f3110", 3'b110, 32'h2000, 32'h0, 1'b1);
        st("st_f3100", 3'b100, 32'h2000, 32'hFFFFFFFF, 1'b1);
        st("sw_mis7",  3'b010, 32'h7001, 32'h00000000, 1'b1);
        check("ledr_keep", o_io_ledr, 32'hDEADBEEF);
        ld("lw_out_end", 3'b010, 32'h7040, 32'h0, 1'b1);
        ld("lw_in_end",  3'b010, 32'h7820, 32'h0, 1'b1);
        ld("lw_2000c", 3'b010, 32'h2000, 32'h11228044, 1'b0);
        ld("lw_2004c", 3'b010, 32'h2004, 32'h12345678, 1'b0);
        ld("lw_hiaddr", 3'b010, 32'h12342000, 32'h11228044, 1'b0);

        // Switch input
        i_io_sw = 32'hA5A50F0F;
        tick();
        tick();
        tick();
        ld("lw_sw",  3'b010, 32'h7800, 32'hA5A50F0F, 1'b0);
        ld("lhu_sw", 3'b101, 32'h7802, 32'h0000A5A5, 1'b0);
        ld("lb_sw",  3'b000, 32'h7801, 32'h0000000F, 1'b0);
        ld("lw_in4", 3'b010, 32'h7804, 32'h0, 1'b0);

        // Button edge capture: flag appears on the 4th edge after the press
        i_io_btn = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            do_req(1'b0, 3'b010, 32'h7814, 32'h0);
            check($sformatf("edge_t%0d", k), o_ld_data, (k == 3) ? 32'h2 : 32'h0);
        end
        ld("lw_btn_hi", 3'b010, 32'h7810, 32'h2, 1'b0);
        i_io_btn = 4'b0000;
        for (int k = 0; k < 4; k++) tick();
        ld("edge_sticky", 3'b010, 32'h7814, 32'h2, 1'b0);
        ld("lw_btn_lo",   3'b010, 32'h7810, 32'h0, 1'b0);
        st("w1c_edge", 3'b000, 32'h7814, 32'h00000002, 1'b0);
        ld("edge_clr", 3'b010, 32'h7814, 32'h0, 1'b0);

        // W1C issued on the same edge the new rise is captured
        i_io_btn = 4'b0010;
        tick();
        tick();
        st("w1c_race", 3'b000, 32'h7814, 32'h00000002, 1'b0);
        ld("edge_race", 3'b010, 32'h7814, 32'h2, 1'b0);
        i_io_btn = 4'b0000;

        // Asynchronous reset while a response is valid
        st("sw_ledr_ff", 3'b010, 32'h7000, 32'h000000FF, 1'b0);
        check("ledr_ff", o_io_ledr, 32'h000000FF);
        do_req(1'b0, 3'b010, 32'h2004, 32'h0);
        check("pre_rst_vld", 32'(o_rsp_valid), 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_vld",  32'(o_rsp_valid), 32'd0);
        check("arst_ledr", o_io_ledr, 32'h0);
        check("arst_ld",   o_ld_data, 32'h0);
        check("arst_hex5", 32'(o_io_hex5), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
